// File: rtl/upcnt_pkg.sv
// upcnt_pkg: shared definitions for the sync_up_counter library slice.
//   - default WIDTH / MODULO constants
//   - upcnt_op_e: per-edge operation, listed in priority order (clear, load,
//     increment, hold)
//   - upcnt_cfg_ok(): clog2-based legality check of a WIDTH/MODULO pair
package upcnt_pkg;

  localparam int unsigned      UPCNT_DEF_WIDTH  = 4;
  localparam longint unsigned  UPCNT_DEF_MODULO = 16;

  typedef enum logic [1:0] {
    UPCNT_OP_CLR,
    UPCNT_OP_LOAD,
    UPCNT_OP_INC,
    UPCNT_OP_HOLD
  } upcnt_op_e;

  // MODULO must fit in WIDTH bits of count range: 2 <= MODULO <= 2**WIDTH.
  function automatic bit upcnt_cfg_ok(input int unsigned     width,
                                      input longint unsigned modulo);
    return (width >= 1) && (width <= 32) && (modulo >= 2) &&
           (int'($clog2(modulo)) <= int'(width));
  endfunction

endpackage

// File: rtl/upcnt_cell.sv
// upcnt_cell: one bit slice of the synchronous up counter.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (bit -> 0)
//   i_t     : toggle request (count enable AND all lower bits set)
//   i_ld    : force the bit to i_d this edge (clear / load / wrap); beats i_t
//   i_d     : value forced when i_ld is high
//   o_q     : registered bit
module upcnt_cell (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_t,
  input  logic i_ld,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (i_ld) begin
      r_q <= i_d;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sync_up_counter.sv
// sync_up_counter: registered up counter, counts 0..MODULO-1 with clear,
// clamped parallel load, combinational terminal-count carry and a
// registered wrap pulse.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : count enable
//   clr      : synchronous clear (highest priority)
//   load     : synchronous load of load_val (clamped to MODULO-1)
//   load_val : load value
//   q        : current count
//   tc       : en && (q == MODULO-1), for cascading into the next stage's en
//   wrap     : one-cycle pulse, high in the cycle q has just wrapped to 0
//   ovf      : sticky wrap flag, cleared by clr/rst_n only; exists only when
//              UPCNT_OVF_STICKY_EN is defined
module sync_up_counter
  import upcnt_pkg::*;
#(
  parameter int unsigned     WIDTH  = UPCNT_DEF_WIDTH,
  parameter longint unsigned MODULO = UPCNT_DEF_MODULO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef UPCNT_OVF_STICKY_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

  if (!upcnt_cfg_ok(WIDTH, MODULO)) begin : g_bad_cfg
    $error("sync_up_counter: illegal WIDTH/MODULO combination");
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_ld;
  logic             w_at_last;
  logic             w_wrap_evt;
  upcnt_op_e        w_op;
  logic             r_wrap;

  assign w_at_last      = (w_q == LAST);
  assign w_load_clamped = (load_val > LAST) ? LAST : load_val;

  // Ripple-free toggle chain: bit i toggles when counting and all lower bits are 1.
  assign w_t[0] = en;
  for (genvar i = 1; i < WIDTH; i++) begin : g_tchain
    assign w_t[i] = w_t[i-1] & w_q[i-1];
  end

  always_comb begin
    w_op = UPCNT_OP_HOLD;
    if (clr) begin
      w_op = UPCNT_OP_CLR;
    end else if (load) begin
      w_op = UPCNT_OP_LOAD;
    end else if (en) begin
      w_op = UPCNT_OP_INC;
    end
  end

  // Clear, load and the wrap back to 0 all override the toggle chain; this
  // keeps a non-power-of-two MODULO from ever registering a value past LAST.
  always_comb begin
    w_ld = 1'b0;
    w_d  = '0;
    unique case (w_op)
      UPCNT_OP_CLR: begin
        w_ld = 1'b1;
        w_d  = '0;
      end
      UPCNT_OP_LOAD: begin
        w_ld = 1'b1;
        w_d  = w_load_clamped;
      end
      UPCNT_OP_INC: begin
        w_ld = w_at_last;
        w_d  = '0;
      end
      default: begin
        w_ld = 1'b0;
        w_d  = '0;
      end
    endcase
  end

  assign w_wrap_evt = (w_op == UPCNT_OP_INC) && w_at_last;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    upcnt_cell u_cell (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_t     (w_t[i]),
      .i_ld    (w_ld),
      .i_d     (w_d[i]),
      .o_q     (w_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_evt;
    end
  end

`ifdef UPCNT_OVF_STICKY_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_op == UPCNT_OP_CLR) begin
      r_ovf <= 1'b0;
    end else if (w_wrap_evt) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

  assign q    = w_q;
  assign tc   = en & w_at_last;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_sync_up_counter.sv
module tb_sync_up_counter;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
`ifdef UPCNT_OVF_STICKY_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: count value, wrap pulse, sticky overflow.
  int unsigned m_q    = 0;
  bit          m_wrap = 1'b0;
  bit          m_ovf  = 1'b0;

  sync_up_counter #(.WIDTH(W), .MODULO(MOD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap)
`ifdef UPCNT_OVF_STICKY_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(m_q));
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
`ifdef UPCNT_OVF_STICKY_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`endif
  endtask

  // One clock cycle: drive at negedge, check tc combinationally, advance the
  // model at the rising edge, check registered outputs just after it.
  task automatic step(input string tag, input bit e, input bit c, input bit l,
                      input int unsigned lv);
    en       = e;
    clr      = c;
    load     = l;
    load_val = W'(lv);
    #1;
    chk({tag, ".tc"}, 32'(tc), 32'(e && (m_q == MOD - 1)));
    @(posedge clk);
    if (rst_n) begin
      if (c) begin
        m_q = 0; m_wrap = 0; m_ovf = 0;
      end else if (l) begin
        m_q = (lv > MOD - 1) ? MOD - 1 : lv;
        m_wrap = 0;
      end else if (e) begin
        m_wrap = (m_q + 1 == MOD);
        m_q    = (m_q + 1) % MOD;
        if (m_wrap) m_ovf = 1;
      end else begin
        m_wrap = 0;
      end
    end
    #1;
    chk_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    int wraps;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #1;
    chk_outputs("async_reset_t0");
    @(negedge clk);

    // Reset held with en=1: nothing counts.
    for (int i = 0; i < 5; i++) step("reset_hold", 1, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_reset", 1, 0, 0, 0);
    chk("post_reset_q3", 32'(q), 32'd3);

    // Free run from 0 for 25 cycles: two wraps.
    step("clr0", 0, 1, 0, 0);
    wraps = 0;
    for (int i = 0; i < 25; i++) begin
      step("free_run", 1, 0, 0, 0);
      if (wrap) wraps++;
    end
    chk("free_run_wraps", 32'(wraps), 32'd2);
    chk("free_run_end_q", 32'(q), 32'd5);

    // Load, clamp, tc after clamp.
    step("load7", 0, 0, 1, 7);
    chk("load7_q", 32'(q), 32'd7);
`ifdef UPCNT_OVF_STICKY_EN
    chk("ovf_survives_load", 32'(ovf), 32'd1);
`endif
    step("load12", 0, 0, 1, 12);
    chk("clamp_q", 32'(q), 32'd9);
    en = 1'b1; load = 1'b0; #1;
    chk("clamp_tc", 32'(tc), 32'd1);

    // Priority at q=9: clr beats load and en.
    step("prio_clr", 1, 1, 1, 5);
    chk("prio_clr_q", 32'(q), 32'd0);
`ifdef UPCNT_OVF_STICKY_EN
    chk("ovf_cleared", 32'(ovf), 32'd0);
`endif
    step("reload9", 0, 0, 1, 9);
    step("prio_load", 1, 0, 1, 5);
    chk("prio_load_q", 32'(q), 32'd5);
    chk("prio_load_wrap", 32'(wrap), 32'd0);

    // Asynchronous reset between edges at q=6.
    step("to6", 1, 0, 0, 0);
    chk("at6_q", 32'(q), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    m_q = 0; m_wrap = 0; m_ovf = 0;
    chk_outputs("async_mid");
    @(negedge clk);
    step("in_reset_ignore", 1, 0, 1, 4);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      step("rand", $urandom_range(0, 3) != 0, r < 4, (r >= 4) && (r < 14),
           $urandom_range(0, 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
